// File: rtl/uart_link_ctrl.sv
// uart_link_ctrl: round-robin TX arbitration with start/done handshake and a
// watchdog, plus a one-entry RX holding register with clear sequencing and
// overrun detection, placed between two byte producers and a single uart.
module uart_link_ctrl #(
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd40000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_valid,
  input  logic [7:0] req0_data,
  output logic       req0_done,
  input  logic       req1_valid,
  input  logic [7:0] req1_data,
  output logic       req1_done,
  output logic       uart_start_tx,
  output logic [7:0] uart_tx_value,
  input  logic       uart_tx_done,
  input  logic       uart_rx_available,
  input  logic [7:0] uart_rx_value,
  output logic       uart_rx_clear,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  input  logic       rx_ready,
  output logic       rx_overrun,
  output logic       tx_timeout,
  input  logic       err_clear,
  output logic       grant
);

  localparam int unsigned DW = 8;
  localparam int unsigned CW = 16;

  typedef enum logic [1:0] {T_IDLE, T_SEND, T_RELEASE} tx_state_e;
  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_CAPTURE, R_CLEAR} rx_state_e;

  tx_state_e       tx_state_q, tx_state_d;
  rx_state_e       rx_state_q, rx_state_d;
  logic            start_q, start_d;
  logic [DW-1:0]   tx_value_q, tx_value_d;
  logic            grant_q, grant_d;
  logic            pref_q, pref_d;
  logic            done0_q, done0_d;
  logic            done1_q, done1_d;
  logic [CW-1:0]   wd_cnt_q, wd_cnt_d;
  logic            timeout_q, timeout_d;
  logic            rx_clear_q, rx_clear_d;
  logic            rx_valid_q, rx_valid_d;
  logic [DW-1:0]   rx_data_q, rx_data_d;
  logic            overrun_q, overrun_d;

  logic            pick;
  logic            wd_expired;
  logic            to_set;
  logic            ov_set;
  logic            pop;

  // Producer choice: the lone requester, or the preferred one when both ask.
  assign pick       = (req0_valid && req1_valid) ? pref_q : ~req0_valid;
  // Watchdog hits after TIMEOUT_CYCLES cycles in T_SEND; zero disables it.
  assign wd_expired = (TIMEOUT_CYCLES != CW'(0)) && (wd_cnt_q == TIMEOUT_CYCLES - CW'(1));
  assign pop        = rx_valid_q & rx_ready;

  // TX next-state: grant, start/done handshake, watchdog and timeout flag.
  always_comb begin
    tx_state_d = tx_state_q;
    start_d    = 1'b0;
    tx_value_d = tx_value_q;
    grant_d    = grant_q;
    pref_d     = pref_q;
    done0_d    = 1'b0;
    done1_d    = 1'b0;
    wd_cnt_d   = wd_cnt_q;
    to_set     = 1'b0;
    unique case (tx_state_q)
      T_IDLE: begin
        if (req0_valid || req1_valid) begin
          grant_d    = pick;
          pref_d     = ~pick;
          tx_value_d = pick ? req1_data : req0_data;
          wd_cnt_d   = '0;
          start_d    = 1'b1;
          tx_state_d = T_SEND;
        end
      end
      T_SEND: begin
        start_d = 1'b1;
        if (uart_tx_done || wd_expired) begin
          start_d    = 1'b0;
          done0_d    = ~grant_q;
          done1_d    = grant_q;
          to_set     = ~uart_tx_done;
          tx_state_d = T_RELEASE;
        end else begin
          wd_cnt_d = wd_cnt_q + CW'(1);
        end
      end
      T_RELEASE: begin
        if (!uart_tx_done) begin
          tx_state_d = T_IDLE;
        end
      end
      default: begin
        tx_state_d = T_IDLE;
      end
    endcase
    timeout_d = to_set | (timeout_q & ~err_clear);
  end

  // RX next-state: wait for registered rx_value, capture or drop, then clear.
  always_comb begin
    rx_state_d = rx_state_q;
    rx_clear_d = 1'b0;
    rx_valid_d = rx_valid_q & ~pop;
    rx_data_d  = rx_data_q;
    ov_set     = 1'b0;
    unique case (rx_state_q)
      R_IDLE: begin
        if (uart_rx_available) begin
          rx_state_d = R_WAIT;
        end
      end
      R_WAIT: begin
        rx_state_d = R_CAPTURE;
      end
      R_CAPTURE: begin
        if (!rx_valid_q || rx_ready) begin
          rx_data_d  = uart_rx_value;
          rx_valid_d = 1'b1;
        end else begin
          ov_set = 1'b1;
        end
        rx_clear_d = 1'b1;
        rx_state_d = R_CLEAR;
      end
      R_CLEAR: begin
        if (uart_rx_available) begin
          rx_clear_d = 1'b1;
        end else begin
          rx_state_d = R_IDLE;
        end
      end
      default: begin
        rx_state_d = R_IDLE;
      end
    endcase
    overrun_d = ov_set | (overrun_q & ~err_clear);
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state_q <= T_IDLE;
      rx_state_q <= R_IDLE;
      start_q    <= 1'b0;
      tx_value_q <= '0;
      grant_q    <= 1'b0;
      pref_q     <= 1'b0;
      done0_q    <= 1'b0;
      done1_q    <= 1'b0;
      wd_cnt_q   <= '0;
      timeout_q  <= 1'b0;
      rx_clear_q <= 1'b0;
      rx_valid_q <= 1'b0;
      rx_data_q  <= '0;
      overrun_q  <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      rx_state_q <= rx_state_d;
      start_q    <= start_d;
      tx_value_q <= tx_value_d;
      grant_q    <= grant_d;
      pref_q     <= pref_d;
      done0_q    <= done0_d;
      done1_q    <= done1_d;
      wd_cnt_q   <= wd_cnt_d;
      timeout_q  <= timeout_d;
      rx_clear_q <= rx_clear_d;
      rx_valid_q <= rx_valid_d;
      rx_data_q  <= rx_data_d;
      overrun_q  <= overrun_d;
    end
  end

  assign uart_start_tx = start_q;
  assign uart_tx_value = tx_value_q;
  assign grant         = grant_q;
  assign req0_done     = done0_q;
  assign req1_done     = done1_q;
  assign tx_timeout    = timeout_q;
  assign uart_rx_clear = rx_clear_q;
  assign rx_valid      = rx_valid_q;
  assign rx_data       = rx_data_q;
  assign rx_overrun    = overrun_q;

endmodule

// File: tb/tb_uart_link_ctrl.sv
// Bench for uart_link_ctrl: directed scenarios plus a randomized phase, with a
// transaction-level reference model compared against the DUT every cycle.
module tb_uart_link_ctrl;

  localparam logic [15:0] TO = 16'd100;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       req0_valid = 1'b0, req1_valid = 1'b0;
  logic [7:0] req0_data = '0, req1_data = '0;
  logic       req0_done, req1_done;
  logic       uart_start_tx;
  logic [7:0] uart_tx_value;
  logic       uart_tx_done = 1'b0;
  logic       uart_rx_available = 1'b0;
  logic [7:0] uart_rx_value = '0;
  logic       uart_rx_clear;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_ready = 1'b0;
  logic       rx_overrun, tx_timeout;
  logic       err_clear = 1'b0;
  logic       grant;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uart_link_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_done(req0_done),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_done(req1_done),
    .uart_start_tx(uart_start_tx), .uart_tx_value(uart_tx_value), .uart_tx_done(uart_tx_done),
    .uart_rx_available(uart_rx_available), .uart_rx_value(uart_rx_value), .uart_rx_clear(uart_rx_clear),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
    .rx_overrun(rx_overrun), .tx_timeout(tx_timeout), .err_clear(err_clear), .grant(grant)
  );

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %b expected %b", nm, $time, act, exp);
    end
  endtask

  task automatic chk8(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %02h expected %02h", nm, $time, act, exp);
    end
  endtask

  task automatic chki(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s @%0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  // Reference model: one outstanding byte with owner, elapsed send time and a
  // release wait; RX tracks age since rx_available was seen.
  bit       m_busy = 0, m_rel = 0, m_pref = 0, m_grant = 0, m_d0 = 0, m_d1 = 0, m_to = 0;
  logic [7:0] m_val = '0, m_rxd = '0;
  bit       m_rxv = 0, m_clr = 0, m_ov = 0;
  int       m_hi = 0, m_rx_age = -1;

  always @(posedge clk or posedge rst) begin
    bit to_set, ov_set, pop;
    if (rst) begin
      m_busy = 0; m_rel = 0; m_pref = 0; m_grant = 0; m_d0 = 0; m_d1 = 0; m_to = 0;
      m_val = '0; m_rxd = '0; m_rxv = 0; m_clr = 0; m_ov = 0; m_hi = 0; m_rx_age = -1;
    end else begin
      to_set = 0; m_d0 = 0; m_d1 = 0;
      if (m_busy) begin
        if (uart_tx_done || (TO != 16'd0 && m_hi + 1 == int'(TO))) begin
          to_set = !uart_tx_done;
          m_busy = 0; m_rel = 1;
          if (m_grant) m_d1 = 1; else m_d0 = 1;
        end else begin
          m_hi++;
        end
      end else if (m_rel) begin
        if (!uart_tx_done) m_rel = 0;
      end else if (req0_valid || req1_valid) begin
        m_grant = (req0_valid && req1_valid) ? m_pref : req1_valid;
        m_pref  = !m_grant;
        m_val   = m_grant ? req1_data : req0_data;
        m_busy  = 1; m_hi = 0;
      end
      m_to = to_set || (m_to && !err_clear);

      ov_set = 0;
      pop = m_rxv && rx_ready;
      if (m_rx_age == 1) begin
        if (!m_rxv || rx_ready) begin
          m_rxd = uart_rx_value; m_rxv = 1;
        end else begin
          ov_set = 1;
        end
        m_rx_age = -1; m_clr = 1;
      end else begin
        if (pop) m_rxv = 0;
        if (m_clr) begin
          if (!uart_rx_available) m_clr = 0;
        end else if (m_rx_age == 0) begin
          m_rx_age = 1;
        end else if (uart_rx_available) begin
          m_rx_age = 0;
        end
      end
      m_ov = ov_set || (m_ov && !err_clear);
    end
  end

  // Cycle compare on the falling edge.
  always @(negedge clk) begin
    chk1("start_tx", uart_start_tx, m_busy);
    chk8("tx_value", uart_tx_value, m_val);
    chk1("grant", grant, m_grant);
    chk1("req0_done", req0_done, m_d0);
    chk1("req1_done", req1_done, m_d1);
    chk1("tx_timeout", tx_timeout, m_to);
    chk1("rx_clear", uart_rx_clear, m_clr);
    chk1("rx_valid", rx_valid, m_rxv);
    chk8("rx_data", rx_data, m_rxd);
    chk1("rx_overrun", rx_overrun, m_ov);
  end

  // Stimulus-side uart and producer models.
  bit         rand_mode = 0, prod_auto = 0, rx_stick = 0, rx_pending = 0, rx_val_set = 0, prev_start = 0;
  int         tx_delay = 0, tx_cnt = 0;
  logic [7:0] rx_next = '0, rx_cur = '0;

  task automatic step();
    int r;
    @(posedge clk);
    #1;
    if (rand_mode && uart_start_tx && !prev_start) begin
      r = int'($urandom_range(0, 19));
      if (r == 0) tx_delay = -1;
      else if (r == 1) tx_delay = 98 + int'($urandom_range(0, 2));
      else tx_delay = int'($urandom_range(0, 40));
    end
    prev_start = uart_start_tx;
    if (uart_tx_done) begin
      if (!uart_start_tx && (!rand_mode || $urandom_range(0, 1) == 0)) uart_tx_done = 1'b0;
    end else if (uart_start_tx) begin
      if (tx_cnt == tx_delay) uart_tx_done = 1'b1;
      else tx_cnt++;
    end else begin
      tx_cnt = 0;
    end

    if (uart_rx_available) begin
      if (!rx_val_set) begin
        uart_rx_value = rx_cur; rx_val_set = 1;
      end else if (uart_rx_clear && !rx_stick && (!rand_mode || $urandom_range(0, 1) == 0)) begin
        uart_rx_available = 1'b0;
      end
    end else if (rx_pending && !uart_rx_clear) begin
      uart_rx_available = 1'b1;
      uart_rx_value = 8'($urandom);
      rx_cur = rx_next; rx_val_set = 0; rx_pending = 0;
    end

    if (rand_mode) begin
      if (!rx_pending && $urandom_range(0, 24) == 0) begin
        rx_pending = 1; rx_next = 8'($urandom);
      end
      rx_ready  = 1'($urandom_range(0, 1));
      err_clear = ($urandom_range(0, 49) == 0);
    end
    if (prod_auto) begin
      if (req0_done) begin
        if ($urandom_range(0, 1) == 1) req0_data = 8'($urandom); else req0_valid = 1'b0;
      end else if (!req0_valid && $urandom_range(0, 3) == 0) begin
        req0_valid = 1'b1; req0_data = 8'($urandom);
      end
      if (req1_done) begin
        if ($urandom_range(0, 1) == 1) req1_data = 8'($urandom); else req1_valid = 1'b0;
      end else if (!req1_valid && $urandom_range(0, 3) == 0) begin
        req1_valid = 1'b1; req1_data = 8'($urandom);
      end
    end
  endtask

  task automatic send_one(input bit p, input logic [7:0] d, input int dly, input int ncyc,
                          output int hi, output int own, output int oth, output logic [7:0] val);
    hi = 0; own = 0; oth = 0; val = '0; tx_delay = dly;
    if (p) begin req1_valid = 1'b1; req1_data = d; end
    else   begin req0_valid = 1'b1; req0_data = d; end
    for (int i = 0; i < ncyc; i++) begin
      step();
      if (uart_start_tx) begin hi++; val = uart_tx_value; end
      if (p ? req1_done : req0_done) begin
        own++;
        if (p) req1_valid = 1'b0; else req0_valid = 1'b0;
      end
      if (p ? req0_done : req1_done) oth++;
    end
  endtask

  task automatic rx_send(input logic [7:0] b);
    int n;
    rx_next = b; rx_pending = 1; n = 0;
    while (n < 30 && (rx_pending || uart_rx_available || uart_rx_clear)) begin
      step(); n++;
    end
    chki("rx_send_bound", int'(n < 30), 1);
  endtask

  initial begin
    int hi, own, oth, n, starts, gap, min_gap;
    int gq[4];
    logic [7:0] val;
    bit prev;

    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk1("rst_start_tx", uart_start_tx, 1'b0);
    chk8("rst_tx_value", uart_tx_value, 8'h00);
    chk1("rst_rx_valid", rx_valid, 1'b0);
    rst = 1'b0;
    step();

    // Single send from producer 0, done 30 cycles after start.
    send_one(1'b0, 8'hA5, 30, 60, hi, own, oth, val);
    chki("single_start_cycles", hi, 31);
    chk8("single_tx_value", val, 8'hA5);
    chki("single_done_owner", own, 1);
    chki("single_done_other", oth, 0);

    // Lone producer 1 with immediate tx_done.
    send_one(1'b1, 8'hC3, 0, 20, hi, own, oth, val);
    chki("p1_start_cycles", hi, 1);
    chk8("p1_tx_value", val, 8'hC3);
    chki("p1_done_owner", own, 1);
    chk1("p1_grant", grant, 1'b1);

    // Contention with both producers held valid.
    req0_valid = 1'b1; req0_data = 8'h11; req1_valid = 1'b1; req1_data = 8'h22; tx_delay = 5;
    n = 0; starts = 0; gap = 0; min_gap = 1000; prev = 0;
    while ((req0_valid || req1_valid || uart_start_tx) && n < 2000) begin
      step(); n++;
      if (uart_start_tx && !prev) begin
        if (starts < 4) gq[starts] = int'(grant);
        starts++;
        if (starts > 1 && gap < min_gap) min_gap = gap;
        gap = 0;
      end
      if (!uart_start_tx) gap++;
      if (starts >= 4 && req0_done) req0_valid = 1'b0;
      if (starts >= 4 && req1_done) req1_valid = 1'b0;
      prev = uart_start_tx;
    end
    chki("cont_bound", int'(n < 2000), 1);
    chki("cont_grant0", gq[0], 0);
    chki("cont_grant1", gq[1], 1);
    chki("cont_grant2", gq[2], 0);
    chki("cont_grant3", gq[3], 1);
    chki("cont_min_gap", min_gap, 2);
    repeat (3) step();

    // RX byte: clear rises on cycle 3 and drops after available falls.
    rx_next = 8'h5A; rx_pending = 1;
    step();
    chk1("rx_avail_up", uart_rx_available, 1'b1);
    n = 0;
    while (!uart_rx_clear && n < 10) begin step(); n++; end
    chki("rx_clear_cycle", n, 3);
    chk8("rx_data_5a", rx_data, 8'h5A);
    chk1("rx_valid_5a", rx_valid, 1'b1);
    step();
    chk1("rx_clear_fall", uart_rx_clear, 1'b0);

    // Overrun, clear, then capture with a same-cycle pop.
    rx_ready = 1'b1; step(); rx_ready = 1'b0;
    chk1("pop_empty", rx_valid, 1'b0);
    rx_send(8'h01);
    rx_send(8'h02);
    chk8("ovr_data", rx_data, 8'h01);
    chk1("ovr_flag", rx_overrun, 1'b1);
    err_clear = 1'b1; step(); err_clear = 1'b0;
    chk1("ovr_cleared", rx_overrun, 1'b0);
    rx_next = 8'h02; rx_pending = 1;
    step(); step(); step();
    rx_ready = 1'b1; step(); rx_ready = 1'b0;
    chk8("popcap_data", rx_data, 8'h02);
    chk1("popcap_valid", rx_valid, 1'b1);
    chk1("popcap_no_ovr", rx_overrun, 1'b0);
    rx_send(8'h00);
    rx_ready = 1'b1; step(); rx_ready = 1'b0;

    // Watchdog: tx_done never rises.
    send_one(1'b0, 8'h3C, -1, 110, hi, own, oth, val);
    chki("wd_start_cycles", hi, int'(TO));
    chki("wd_done_owner", own, 1);
    chk1("wd_timeout", tx_timeout, 1'b1);
    chk1("wd_start_low", uart_start_tx, 1'b0);
    err_clear = 1'b1; step(); err_clear = 1'b0;
    chk1("wd_cleared", tx_timeout, 1'b0);

    // Reset while TX is in T_SEND and RX is in R_CLEAR.
    req1_valid = 1'b1; req1_data = 8'h99; tx_delay = -1;
    rx_stick = 1; rx_next = 8'h77; rx_pending = 1;
    repeat (8) step();
    chk1("pre_rst_start", uart_start_tx, 1'b1);
    chk1("pre_rst_clear", uart_rx_clear, 1'b1);
    chk1("pre_rst_valid", rx_valid, 1'b1);
    chk1("pre_rst_grant", grant, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk1("arst_start", uart_start_tx, 1'b0);
    chk1("arst_clear", uart_rx_clear, 1'b0);
    chk1("arst_valid", rx_valid, 1'b0);
    chk1("arst_done0", req0_done, 1'b0);
    chk1("arst_done1", req1_done, 1'b0);
    chk1("arst_grant", grant, 1'b0);
    chk8("arst_value", uart_tx_value, 8'h00);
    req1_valid = 1'b0; uart_tx_done = 1'b0; uart_rx_available = 1'b0;
    tx_cnt = 0; rx_stick = 0; rx_pending = 0; prev_start = 0;
    @(posedge clk);
    #1 rst = 1'b0;
    step();
    chk1("post_rst_start", uart_start_tx, 1'b0);

    // Randomized traffic on both sides.
    rand_mode = 1; prod_auto = 1;
    repeat (6000) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_link_ctrl.md
Name: uart_link_ctrl

Overview:
- Sits between two byte producers (CPU store path, debug/boot path) and the single uart instance.
- Arbitrates the uart TX side round-robin and sequences its start_tx / tx_done level handshake.
- Drains the uart RX side through a one-entry holding register with a valid/ready interface, an rx_clear sequence and overrun detection.
- Includes a TX watchdog for the case where clear_to_send blocks transmission.

Parameters:
- TIMEOUT_CYCLES, 16'd40000: cycles in T_SEND without tx_done before abort. Must exceed one frame, about 25020 cycles at the 9600-baud divider. 0 disables the watchdog.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- req0_valid  in  1  producer 0 has a byte; held until req0_done
- req0_data  in  8  producer 0 byte; stable while req0_valid
- req0_done  out  1  one-cycle pulse: producer 0 byte finished or aborted
- req1_valid, req1_data, req1_done  in/in/out  1/8/1  same as producer 0, for producer 1
- uart_start_tx  out  1  to uart start_tx
- uart_tx_value  out  8  to uart tx_value (registered)
- uart_tx_done  in  1  from uart tx_done
- uart_rx_available  in  1  from uart rx_available
- uart_rx_value  in  8  from uart rx_value
- uart_rx_clear  out  1  to uart rx_clear
- rx_valid  out  1  holding register full
- rx_data  out  8  held byte
- rx_ready  in  1  consumer accepts; pops when rx_valid & rx_ready
- rx_overrun  out  1  sticky: byte dropped because holding register was full
- tx_timeout  out  1  sticky: watchdog fired
- err_clear  in  1  clears rx_overrun and tx_timeout
- grant  out  1  id of last/current granted producer

Behaviour:
- Reset (asynchronous, any state):
  - all outputs 0, uart_tx_value 0, grant 0
  - TX FSM to T_IDLE, RX FSM to R_IDLE, holding register empty
  - round-robin pointer favours producer 0 first
- TX FSM states: T_IDLE, T_SEND, T_RELEASE.
  - T_IDLE: if any reqN_valid, pick a producer.
    - If only one is valid, grant it.
    - If both are valid, grant the one not granted last.
    - Latch its data into uart_tx_value, set grant, go to T_SEND. uart_start_tx rises the next cycle.
  - T_SEND: uart_start_tx=1; watchdog counts from 0.
    - On uart_tx_done=1: pulse reqN_done (granted producer only) in that cycle, go to T_RELEASE.
    - If TIMEOUT_CYCLES != 0 and the count reaches TIMEOUT_CYCLES with no tx_done: set tx_timeout, pulse reqN_done, go to T_RELEASE.
  - T_RELEASE: uart_start_tx=0. Wait until uart_tx_done=0, then go to T_IDLE. This guarantees the uart is back in idle before the next start.
  - No re-grant happens in the cycle the FSM returns to T_IDLE. Minimum gap between bytes: 1 idle cycle.
  - A producer dropping valid mid-transfer is illegal; the transfer completes regardless.
- RX FSM states: R_IDLE, R_WAIT, R_CAPTURE, R_CLEAR.
  - R_IDLE: uart_rx_clear=0. On uart_rx_available=1, go to R_WAIT.
  - R_WAIT: one cycle, because uart rx_value is registered one cycle after rx_available rises. Go to R_CAPTURE.
  - R_CAPTURE: one cycle.
    - If the holding register is empty, or a pop happens in the same cycle: load uart_rx_value, rx_valid=1.
    - Otherwise: drop the new byte, keep the old byte, set rx_overrun.
    - Go to R_CLEAR.
  - R_CLEAR: uart_rx_clear=1 until uart_rx_available=0 is sampled, then go to R_IDLE with rx_clear=0 the next cycle. Holding rx_clear high longer would block the uart from detecting the next start bit.
- TX and RX FSMs run independently. A start_tx held while the uart is receiving is legal; the uart starts TX after the RX clear completes.
- Sticky flags: err_clear clears both. If a set and err_clear occur in the same cycle, the set wins.
- Pop: rx_valid & rx_ready clears rx_valid the next cycle unless a capture happens in the same cycle.

Test Plan:
- Single send: req0_valid with 0xA5, uart model asserts tx_done 30 cycles after start → uart_tx_value=0xA5, start_tx high exactly while in T_SEND, req0_done one pulse, start_tx low before the next grant.
- Contention: req0 and req1 valid together, 0x11 and 0x22, kept valid → grant order 0,1,0,1. Each byte's done pulse goes only to its owner; ≥1 idle cycle between start_tx pulses.
- RX path: rx_available rises, rx_value=0x5A one cycle later → rx_data=0x5A, rx_valid=1. rx_clear asserted from cycle 3 until rx_available falls, then 0.
- Overrun: two RX bytes 0x01, 0x02 with rx_ready=0 → rx_data stays 0x01, rx_overrun=1. err_clear → 0. Repeat with rx_ready=1 in the capture cycle → 0x02 loaded, no overrun.
- Watchdog: TIMEOUT_CYCLES=100, tx_done never rises → at cycle 100 in T_SEND: tx_timeout=1, req0_done pulse, start_tx=0, FSM back to T_IDLE.
- Reset mid-transfer: rst pulsed during T_SEND and R_CLEAR → start_tx, rx_clear, rx_valid and all done pulses go 0 immediately (asynchronously); grant=0.
